lcd_frame_streamer: RTL
=======================

LCD_FRAME_STREAMER -- requirements
Module: lcd_frame_streamer

Interface
REQ-001 Parameter ROWS, default 10, grid rows.
REQ-002 Parameter COLS, default 10, grid columns.
REQ-003 Parameter CELL_PX, default 6, square pixel size of one grid cell.
REQ-004 Parameter AUTO_REFRESH, default 0: 1 starts a frame whenever grid differs from the last drawn snapshot.
REQ-005 Port clk  input  1  single clock for all logic.
REQ-006 Port rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port grid  input  ROWS*COLS  cell bitmap; cell (r,c) is bit r*COLS+c; 1 = filled.
REQ-008 Port change  input  1  frame request; level-sampled each cycle.
REQ-009 Port invert  input  1  invert all output pixels; sampled only at frame start.
REQ-010 Port en  input  1  one-cycle consumer acknowledge of the presented byte.
REQ-011 Port data_out  output  8  page/column byte for a 128x64 two-half LCD.
REQ-012 Port data_valid  output  1  data_out holds a valid unacknowledged byte.
REQ-013 Port busy  output  1  frame in progress.
REQ-014 Port frame_done  output  1  one-cycle pulse after the last byte of a frame is acknowledged.

Function
REQ-015 States SHALL be IDLE, LOAD, PRESENT, ADVANCE, DONE.
REQ-016 IDLE->LOAD when change=1, or when AUTO_REFRESH=1 and grid differs from snapshot.
REQ-017 LOAD SHALL copy grid and invert into internal registers, zero page/column counters, and go to PRESENT the next cycle.
REQ-018 Frame order: pages 0..7 outer, columns x=0..127 inner; 1024 bytes per frame.
REQ-019 Byte bit b for page p, column x SHALL be pixel (x, y=8p+b).
REQ-020 Pixel = snapshot cell (y/CELL_PX, x/CELL_PX) if x<COLS*CELL_PX and y<ROWS*CELL_PX, else 0; then XOR inverted flag.
REQ-021 Cell indices SHALL come from incremental sub-counters (no dividers); all column counters wrap at 128, page counter at 8.
REQ-022 In PRESENT, data_valid=1 and data_out SHALL be stable until en=1; en while data_valid=0 SHALL be ignored.
REQ-023 en in PRESENT -> ADVANCE (data_valid=0 for one cycle), next byte valid in PRESENT the following cycle; byte-to-byte latency is 2 cycles after en.
REQ-024 en on byte (page 7, x 127) -> DONE; DONE pulses frame_done for one cycle, then returns to IDLE.
REQ-025 change=1 while busy SHALL set a pending flag; pending SHALL start a new frame directly from DONE (DONE->LOAD) and clear on LOAD.
REQ-026 grid changes during a frame SHALL NOT affect the bytes of that frame.
REQ-027 busy=1 in LOAD, PRESENT, ADVANCE, DONE; 0 in IDLE.
REQ-028 Elaboration SHALL fail if ROWS*CELL_PX>64, COLS*CELL_PX>128, or any parameter is 0.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, data_out=8'h00, data_valid=0, busy=0, frame_done=0, pending=0, counters=0, snapshot=0, inverted flag=0.
REQ-030 Reset mid-frame SHALL abandon the frame; no frame_done pulse; after release a new change is needed.

Structure
REQ-031 State encoding, LCD geometry constants (128 columns, 8 pages, 64-column half width) SHALL live in a shared package lcd_pkg.
REQ-032 Pixel/byte generation SHALL be one sub-module lcd_pixel_gen (snapshot, counters -> byte, registered).

Verification
REQ-033 Defaults, grid bit 0 only, change pulse, en every 3rd cycle -> byte 0 = 8'h3F for x=0..5 of page 0, 8'h00 for x>=6; 1024 bytes then one frame_done.
REQ-034 All grid bits 1, invert=1 -> page 7 (y 56..63, outside 60 rows) bytes = 8'hF0 for x<60, all 8'hFF for x>=60; pages 0..6 = 8'h00 for x<60.
REQ-035 data_valid held, en withheld 50 cycles -> data_out unchanged; en while data_valid=0 -> no counter advance.
REQ-036 change during byte 500 -> frame_done, then LOAD next cycle, second frame of 1024 bytes; grid changed mid-frame appears only in second frame.
REQ-037 AUTO_REFRESH=1: toggle grid bit 37 in IDLE -> frame starts within 2 cycles; unchanged grid -> stays IDLE.
REQ-038 rst_n low at byte 300 -> all outputs reset immediately, IDLE after release, no frame_done.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state encoding and LCD geometry for the frame streamer
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PRESENT = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_DONE    = 3'd4
    } lcd_state_t;

    // 128x64 panel built from two 64-column halves, addressed as 8 pages of 8 rows
    localparam int LCD_COLS      = 128;
    localparam int LCD_ROWS      = 64;
    localparam int LCD_PAGES     = 8;
    localparam int LCD_HALF_COLS = 64;

endpackage

// File: rtl/lcd_pixel_gen.sv
// rtl/lcd_pixel_gen.sv - grid snapshot, page/column walk and registered byte generation
module lcd_pixel_gen
    import lcd_pkg::*;
#(
    parameter int ROWS    = 10,
    parameter int COLS    = 10,
    parameter int CELL_PX = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 gen,
    input  logic [ROWS*COLS-1:0] grid,
    input  logic                 invert,
    output logic [ROWS*COLS-1:0] snapshot,
    output logic [7:0]           data_out,
    output logic                 last_byte
);

    logic                 inv_flag;
    logic [6:0]           x;
    logic [2:0]           page;
    logic [7:0]           sub_x;
    logic [7:0]           cell_x;
    logic [7:0]           cell_y;
    logic [7:0]           sub_y;
    logic [ROWS*COLS-1:0] src_grid;
    logic                 src_inv;
    logic [7:0]           cur_x;
    logic [7:0]           walk_y;
    logic [7:0]           walk_sub;
    logic [ROWS-1:0]      col_bits;
    logic [7:0]           pix_byte;

    assign last_byte = (page == 3'(LCD_PAGES - 1)) && (x == 7'(LCD_COLS - 1));

    // Build the byte for the current page/column; during LOAD the live inputs stand in for the
    // snapshot so the first byte is ready on entry to PRESENT. Cells outside the grid never match
    // a select below and read as 0. The row walk ends on the first row of the next page.
    always_comb begin
        src_grid = load ? grid : snapshot;
        src_inv  = load ? invert : inv_flag;
        cur_x    = load ? 8'd0 : cell_x;
        walk_y   = load ? 8'd0 : cell_y;
        walk_sub = load ? 8'd0 : sub_y;
        col_bits = '0;
        for (int j = 0; j < COLS; j++) begin
            if (cur_x == 8'(j)) begin
                for (int i = 0; i < ROWS; i++) begin
                    col_bits[i] = src_grid[i*COLS + j];
                end
            end
        end
        pix_byte = '0;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < ROWS; i++) begin
                if (walk_y == 8'(i)) begin
                    pix_byte[b] = col_bits[i];
                end
            end
            pix_byte[b] = pix_byte[b] ^ src_inv;
            if (walk_sub == 8'(CELL_PX - 1)) begin
                walk_sub = 8'd0;
                walk_y   = walk_y + 8'd1;
            end else begin
                walk_sub = walk_sub + 8'd1;
            end
        end
    end

    // Snapshot capture and incremental column/page counters (x wraps at 128, page at 8)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot <= '0;
            inv_flag <= 1'b0;
            x        <= '0;
            page     <= '0;
            sub_x    <= '0;
            cell_x   <= '0;
            cell_y   <= '0;
            sub_y    <= '0;
        end else if (load) begin
            snapshot <= grid;
            inv_flag <= invert;
            x        <= '0;
            page     <= '0;
            sub_x    <= '0;
            cell_x   <= '0;
            cell_y   <= '0;
            sub_y    <= '0;
        end else if (step) begin
            if (x == 7'(LCD_COLS - 1)) begin
                x      <= '0;
                sub_x  <= '0;
                cell_x <= '0;
                if (page == 3'(LCD_PAGES - 1)) begin
                    page   <= '0;
                    cell_y <= '0;
                    sub_y  <= '0;
                end else begin
                    page   <= page + 3'd1;
                    cell_y <= walk_y;
                    sub_y  <= walk_sub;
                end
            end else begin
                x <= x + 7'd1;
                if (sub_x == 8'(CELL_PX - 1)) begin
                    sub_x  <= '0;
                    cell_x <= cell_x + 8'd1;
                end else begin
                    sub_x <= sub_x + 8'd1;
                end
            end
        end
    end

    // Output byte register, refreshed in LOAD and ADVANCE only so it holds steady in PRESENT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= 8'h00;
        end else if (gen) begin
            data_out <= pix_byte;
        end
    end

endmodule

// File: rtl/lcd_frame_streamer.sv
// rtl/lcd_frame_streamer.sv - streams a cell-grid bitmap as page/column bytes for a 128x64 LCD
module lcd_frame_streamer
    import lcd_pkg::*;
#(
    parameter int ROWS         = 10,
    parameter int COLS         = 10,
    parameter int CELL_PX      = 6,
    parameter int AUTO_REFRESH = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS*COLS-1:0] grid,
    input  logic                 change,
    input  logic                 invert,
    input  logic                 en,
    output logic [7:0]           data_out,
    output logic                 data_valid,
    output logic                 busy,
    output logic                 frame_done
);

    if (ROWS == 0 || COLS == 0 || CELL_PX == 0 ||
        ROWS * CELL_PX > LCD_ROWS || COLS * CELL_PX > LCD_COLS) begin : g_bad_geometry
        $error("lcd_frame_streamer: grid does not fit the 128x64 panel or a parameter is zero");
    end

    lcd_state_t           state;
    lcd_state_t           next_state;
    logic                 pending;
    logic                 load;
    logic                 step;
    logic                 gen;
    logic                 last_byte;
    logic [ROWS*COLS-1:0] snapshot;
    logic                 auto_req;

    assign auto_req = (AUTO_REFRESH != 0) && (grid != snapshot);

    lcd_pixel_gen #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .CELL_PX (CELL_PX)
    ) u_pixel_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .gen       (gen),
        .grid      (grid),
        .invert    (invert),
        .snapshot  (snapshot),
        .data_out  (data_out),
        .last_byte (last_byte)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Remember a frame request that arrives while a frame is already running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (state == ST_LOAD) begin
            pending <= 1'b0;
        end else if (change && state != ST_IDLE) begin
            pending <= 1'b1;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (change || auto_req) next_state = ST_LOAD;
            ST_LOAD:    next_state = ST_PRESENT;
            ST_PRESENT: if (en) next_state = last_byte ? ST_DONE : ST_ADVANCE;
            ST_ADVANCE: next_state = ST_PRESENT;
            ST_DONE:    next_state = (pending || change) ? ST_LOAD : ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs and datapath controls decoded from the current state
    always_comb begin
        data_valid = (state == ST_PRESENT);
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_DONE);
        load       = (state == ST_LOAD);
        step       = (state == ST_PRESENT) && en;
        gen        = (state == ST_LOAD) || (state == ST_ADVANCE);
    end

endmodule
